// File: rtl/seven_seg_scanner_if.sv
// Display bus between the datapath and seven_seg_scanner: hex value, sign, load/blank
// controls in; active-low segment, decimal-point and anode drives plus frame pulse out.
interface seven_seg_scanner_if #(
   parameter int DIGITS = 4
);
   logic [4*DIGITS-1:0] value;
   logic                sign;
   logic                load;
   logic                blank;
   logic [6:0]          seg;
   logic                dp;
   logic [DIGITS-1:0]   an;
   logic                frame_done;

   modport master (
      output value, sign, load, blank,
      input  seg, dp, an, frame_done
   );

   modport slave (
      input  value, sign, load, blank,
      output seg, dp, an, frame_done
   );
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode seven-segment scanner with latched hex value and sign.
// Define LZ_BLANK_EN to blank leading zero digits (digit 0 is always shown).
module seven_seg_scanner #(
   parameter int DIGITS  = 4,
   parameter int CLK_DIV = 100000
) (
   input logic                clk,
   input logic                reset,
   seven_seg_scanner_if.slave bus
);
   localparam int CW = $clog2(CLK_DIV);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

   logic [CW-1:0]       cnt;
   logic [IW-1:0]       idx;
   logic [4*DIGITS-1:0] disp;
   logic                dsign;

   logic                advance;
   logic                wrap;
   logic [3:0]          nib;
   logic [DIGITS-1:0]   an_sel;
   logic                digit_blank;
`ifdef LZ_BLANK_EN
   logic                zero_above;
`endif

   function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
      case (h)
         4'h0: hex_to_seg = 7'h01;
         4'h1: hex_to_seg = 7'h4F;
         4'h2: hex_to_seg = 7'h12;
         4'h3: hex_to_seg = 7'h06;
         4'h4: hex_to_seg = 7'h4C;
         4'h5: hex_to_seg = 7'h24;
         4'h6: hex_to_seg = 7'h20;
         4'h7: hex_to_seg = 7'h0F;
         4'h8: hex_to_seg = 7'h00;
         4'h9: hex_to_seg = 7'h0C;
         4'hA: hex_to_seg = 7'h08;
         4'hB: hex_to_seg = 7'h60;
         4'hC: hex_to_seg = 7'h31;
         4'hD: hex_to_seg = 7'h42;
         4'hE: hex_to_seg = 7'h30;
         default: hex_to_seg = 7'h38;
      endcase
   endfunction

   assign advance = (cnt == CNT_LAST);
   assign wrap    = advance && (idx == IDX_LAST);

   always_comb begin
      // NOTE: defaults first so no path through the loop leaves a signal unassigned (no latch).
      nib         = '0;
      an_sel      = '1;
      digit_blank = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx == IW'(i)) begin
            nib       = disp[4*i +: 4];
            an_sel[i] = 1'b0;
         end
      end
`ifdef LZ_BLANK_EN
      // Walk down from the top nibble; a digit is a leading zero while everything above it is zero.
      zero_above = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zero_above = zero_above && (disp[4*i +: 4] == 4'h0);
         if (zero_above && (idx == IW'(i)))
            digit_blank = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt            <= '0;
         idx            <= '0;
         disp           <= '0;
         dsign          <= 1'b0;
         bus.seg        <= 7'h7F;
         bus.dp         <= 1'b1;
         bus.an         <= '1;
         bus.frame_done <= 1'b0;
      end else begin
         // NOTE: non-blocking, so the output update below sees pre-edge idx and disp.
         cnt <= advance ? '0 : cnt + CW'(1);
         if (advance)
            idx <= wrap ? '0 : idx + IW'(1);
         if (bus.load) begin
            disp  <= bus.value;
            dsign <= bus.sign;
         end
         bus.frame_done <= wrap;
         if (bus.blank) begin
            bus.seg <= 7'h7F;
            bus.dp  <= 1'b1;
            bus.an  <= '1;
         end else begin
            bus.seg <= digit_blank ? 7'h7F : hex_to_seg(nib);
            bus.dp  <= ~(dsign && (idx == IDX_LAST));
            bus.an  <= an_sel;
         end
      end
   end
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner (DIGITS=4, CLK_DIV=4): directed vector table, hand-written
// corner sequences and randomized traffic against a cycle-count based reference model.
module tb_seven_seg_scanner;
   localparam int DIGITS  = 4;
   localparam int CLK_DIV = 4;
   localparam int FRAME   = DIGITS * CLK_DIV;

   logic clk;
   logic reset;
   seven_seg_scanner_if #(.DIGITS(DIGITS)) bus ();

   seven_seg_scanner #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        ld;
      logic [15:0] val;
      logic        sg;
      logic        blk;
      logic [3:0]  an;
      logic [6:0]  seg;
      logic        dp;
      logic        fd;
   } vec_t;

   int n_checks = 0;
   int n_errors = 0;

   logic [6:0]  seg_tbl [16];
   int          m_e;
   logic [15:0] m_disp;
   logic        m_dsign;
   logic [3:0]  exp_an;
   logic [6:0]  exp_seg;
   logic        exp_dp;
   logic        exp_fd;
   logic [6:0]  zero_pat;

   task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: {an,seg,dp,fd} got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: outputs after the e-th edge since reset show digit (e-1)/CLK_DIV mod DIGITS,
   // built from the display contents held before that edge; frames end every FRAME edges.
   task automatic model_step(input logic r, input logic l, input logic [15:0] v,
                             input logic s, input logic b);
      int d;
      logic [3:0] n;
      if (r) begin
         m_e = 0; m_disp = '0; m_dsign = 1'b0;
         exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fd = 1'b0;
      end else begin
         m_e++;
         d = ((m_e - 1) / CLK_DIV) % DIGITS;
         n = 4'((m_disp >> (4 * d)) & 16'hF);
         exp_fd = (m_e % FRAME == 0);
         if (b) begin
            exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
         end else begin
            exp_an  = 4'hF & ~(4'd1 << d);
            exp_seg = seg_tbl[n];
`ifdef LZ_BLANK_EN
            if (d > 0 && (m_disp >> (4 * d)) == 0) exp_seg = 7'h7F;
`endif
            exp_dp = !(d == DIGITS - 1 && m_dsign);
         end
         if (l) begin
            m_disp = v; m_dsign = s;
         end
      end
   endtask

   task automatic tick(input logic r, input logic l, input logic [15:0] v,
                       input logic s, input logic b);
      reset = r; bus.load = l; bus.value = v; bus.sign = s; bus.blank = b;
      model_step(r, l, v, s, b);
      @(posedge clk);
      #1;
      check("model", {bus.an, bus.seg, bus.dp, bus.frame_done}, {exp_an, exp_seg, exp_dp, exp_fd});
   endtask

   vec_t vecs[19];

   initial begin
      int d;
      logic [6:0] dseg;
      seg_tbl = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                  7'h00, 7'h0C, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
`ifdef LZ_BLANK_EN
      zero_pat = 7'h7F;
`else
      zero_pat = 7'h01;
`endif
      m_e = 0; m_disp = '0; m_dsign = 1'b0;

      // Reset, then load 1A3F and watch one full frame plus the wrap.
      vecs[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 4'hF, 7'h7F, 1'b1, 1'b0};
      vecs[1]  = '{1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b1, 4'hF, 7'h7F, 1'b1, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 16'h1A3F, 1'b0, 1'b0, 4'hE, 7'h01, 1'b1, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'hE, 7'h38, 1'b1, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'hE, 7'h38, 1'b1, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'hE, 7'h38, 1'b1, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'hD, 7'h06, 1'b1, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'hD, 7'h06, 1'b1, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'hD, 7'h06, 1'b1, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'hD, 7'h06, 1'b1, 1'b0};
      vecs[10] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'hB, 7'h08, 1'b1, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'hB, 7'h08, 1'b1, 1'b0};
      vecs[12] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'hB, 7'h08, 1'b1, 1'b0};
      vecs[13] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'hB, 7'h08, 1'b1, 1'b0};
      vecs[14] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'h7, 7'h4F, 1'b1, 1'b0};
      vecs[15] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'h7, 7'h4F, 1'b1, 1'b0};
      vecs[16] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'h7, 7'h4F, 1'b1, 1'b0};
      vecs[17] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'h7, 7'h4F, 1'b1, 1'b1};
      vecs[18] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'hE, 7'h38, 1'b1, 1'b0};

      for (int i = 0; i < 19; i++) begin
         tick(vecs[i].rst, vecs[i].ld, vecs[i].val, vecs[i].sg, vecs[i].blk);
         check($sformatf("vec%0d", i), {bus.an, bus.seg, bus.dp, bus.frame_done},
               {vecs[i].an, vecs[i].seg, vecs[i].dp, vecs[i].fd});
      end

      // Sign on the top digit's decimal point, with leading zeros (blanked if enabled).
      tick(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
      tick(1'b0, 1'b1, 16'h0005, 1'b1, 1'b0);
      for (int e = 2; e <= 17; e++) begin
         tick(1'b0, 1'b0, 16'($urandom), 1'($urandom_range(1)), 1'b0);
         d = ((e - 1) / CLK_DIV) % DIGITS;
         dseg = (d == 0) ? 7'h24 : zero_pat;
         check($sformatf("sign_e%0d", e), {bus.an, bus.seg, bus.dp, bus.frame_done},
               {4'hF & ~(4'd1 << d), dseg, (d == 3) ? 1'b0 : 1'b1, (e == 16) ? 1'b1 : 1'b0});
      end

      // Blank for 10 cycles while value wiggles without load; scan phase keeps running.
      for (int k = 0; k < 10; k++) begin
         tick(1'b0, 1'b0, 16'($urandom), 1'b1, 1'b1);
         check($sformatf("blank%0d", k), {bus.an, bus.seg, bus.dp, 1'b0},
               {4'hF, 7'h7F, 1'b1, 1'b0});
      end
      tick(1'b0, 1'b0, 16'hBEEF, 1'b0, 1'b0);
      check("blank_resume", {bus.an, bus.seg, bus.dp, 1'b0}, {4'hB, zero_pat, 1'b1, 1'b0});
      for (int k = 0; k < 6; k++) tick(1'b0, 1'b0, 16'($urandom), 1'b0, 1'b0);

      // Reset while the digit index is 2, then a full dwell on digit 0 with cleared disp.
      for (int k = 0; k < FRAME && ((m_e / CLK_DIV) % DIGITS) != 2; k++)
         tick(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      check("reach_idx2", 13'((m_e / CLK_DIV) % DIGITS), 13'd2);
      tick(1'b1, 1'b1, 16'h9999, 1'b1, 1'b1);
      check("midscan_rst", {bus.an, bus.seg, bus.dp, bus.frame_done}, {4'hF, 7'h7F, 1'b1, 1'b0});
      for (int k = 0; k < 4; k++) begin
         tick(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
         check($sformatf("restart%0d", k), {bus.an, bus.seg, bus.dp, bus.frame_done},
               {4'hE, 7'h01, 1'b1, 1'b0});
      end
      tick(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      check("restart_adv", {bus.an, bus.seg, bus.dp, bus.frame_done}, {4'hD, zero_pat, 1'b1, 1'b0});

      // Randomized traffic against the model, including occasional resets and small values.
      for (int k = 0; k < 600; k++) begin
         tick(1'($urandom_range(63) == 0),
              1'($urandom_range(5) == 0),
              ($urandom_range(1) == 1) ? 16'($urandom) : 16'($urandom_range(255)),
              1'($urandom_range(1)),
              1'($urandom_range(7) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
